// File: rtl/regfile_param_if.sv
// rtl/regfile_param_if.sv - decode/writeback access bus of the parametrised register file
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0]   rna;
  logic [ADDR_W-1:0]   rnb;
  logic [DATA_W-1:0]   qa;
  logic [DATA_W-1:0]   qb;
  logic [ADDR_W-1:0]   wn;
  logic [DATA_W-1:0]   d;
  logic                we;
  logic [DATA_W/8-1:0] wbe;
  logic                set_busy;
  logic [ADDR_W-1:0]   bn;
  logic                busy_a;
  logic                busy_b;

  modport master (
    output rna, rnb, wn, d, we, wbe, set_busy, bn,
    input  qa, qb, busy_a, busy_b
  );

  modport slave (
    input  rna, rnb, wn, d, we, wbe, set_busy, bn,
    output qa, qb, busy_a, busy_b
  );
endinterface

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - dual-read, single byte-enabled write register file
// with optional write-to-read bypass and per-register busy scoreboard
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic             clk,
  input logic             clrn,
  regfile_param_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_W;
  localparam int NB   = DATA_W / 8;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_busy;

  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_merged;
  logic              w_wr_en;
  logic              w_set_en;
  logic              w_zero_a;
  logic              w_zero_b;
  logic              w_fwd_a;
  logic              w_fwd_b;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NB; i++) begin
      w_mask[8*i +: 8] = {8{bus.wbe[i]}};
    end
  end

  // w_merged is exactly what regs[wn] will hold after the edge, so the
  // bypass path and the storage path can never disagree.
  assign w_merged = (r_regs[bus.wn] & ~w_mask) | (bus.d & w_mask);
  assign w_wr_en  = bus.we && !((ZERO_REG != 0) && (bus.wn == '0));
  assign w_set_en = bus.set_busy && !((ZERO_REG != 0) && (bus.bn == '0));
  assign w_zero_a = (ZERO_REG != 0) && (bus.rna == '0);
  assign w_zero_b = (ZERO_REG != 0) && (bus.rnb == '0);
  assign w_fwd_a  = (BYPASS != 0) && w_wr_en && (bus.wn == bus.rna);
  assign w_fwd_b  = (BYPASS != 0) && w_wr_en && (bus.wn == bus.rnb);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr_en) begin
        r_regs[bus.wn] <= w_merged;
      end
      if (bus.we) begin
        r_busy[bus.wn] <= 1'b0;
      end
      // Issued after the clear so a new producer on the same edge wins.
      if (w_set_en) begin
        r_busy[bus.bn] <= 1'b1;
      end
    end
  end

  // Gating with clrn keeps a live bypass from leaking data while in reset.
  always_comb begin
    bus.qa     = r_regs[bus.rna];
    bus.busy_a = r_busy[bus.rna];
    if (!clrn || w_zero_a) begin
      bus.qa     = '0;
      bus.busy_a = 1'b0;
    end else if (w_fwd_a) begin
      bus.qa     = w_merged;
      bus.busy_a = 1'b0;
    end
  end

  always_comb begin
    bus.qb     = r_regs[bus.rnb];
    bus.busy_b = r_busy[bus.rnb];
    if (!clrn || w_zero_b) begin
      bus.qb     = '0;
      bus.busy_b = 1'b0;
    end else if (w_fwd_b) begin
      bus.qb     = w_merged;
      bus.busy_b = 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - bench for regfile_param (bypass and non-bypass builds side by side)
module tb_regfile_param;
  logic clk;
  logic clrn;
  int   n_cmp;
  int   n_err;

  regfile_param_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regfile_param_if #(.DATA_W(32), .ADDR_W(5)) bus_nb ();

  assign bus_nb.rna      = bus.rna;
  assign bus_nb.rnb      = bus.rnb;
  assign bus_nb.wn       = bus.wn;
  assign bus_nb.d        = bus.d;
  assign bus_nb.we       = bus.we;
  assign bus_nb.wbe      = bus.wbe;
  assign bus_nb.set_busy = bus.set_busy;
  assign bus_nb.bn       = bus.bn;

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus_nb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arrays holding architectural register and busy state.
  logic [31:0] m_regs [32];
  logic        m_busy [32];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_q(input logic [4:0] idx, input bit byp);
    if (idx == 0) return 32'h0;
    if (byp && bus.we && bus.wn == idx) return merge(m_regs[idx], bus.d, bus.wbe);
    return m_regs[idx];
  endfunction

  function automatic logic exp_b(input logic [4:0] idx);
    if (idx == 0) return 1'b0;
    if (bus.we && bus.wn == idx) return 1'b0;
    return m_busy[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    if (bus.we && bus.wn != 0) m_regs[bus.wn] = merge(m_regs[bus.wn], bus.d, bus.wbe);
    if (bus.we) m_busy[bus.wn] = 1'b0;
    if (bus.set_busy && bus.bn != 0) m_busy[bus.bn] = 1'b1;
  endtask

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", name, tag, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wn, input logic [31:0] d, input logic [3:0] wbe,
                       input logic sb, input logic [4:0] bn, input logic [4:0] rna, input logic [4:0] rnb);
    bus.we = we; bus.wn = wn; bus.d = d; bus.wbe = wbe;
    bus.set_busy = sb; bus.bn = bn; bus.rna = rna; bus.rnb = rnb;
  endtask

  task automatic step(input logic we, input logic [4:0] wn, input logic [31:0] d, input logic [3:0] wbe,
                      input logic sb, input logic [4:0] bn, input logic [4:0] rna, input logic [4:0] rnb);
    @(negedge clk);
    drive(we, wn, d, wbe, sb, bn, rna, rnb);
    @(posedge clk);
    model_step();
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wn;
    logic [31:0] d;
    logic [3:0]  wbe;
    logic        sb;
    logic [4:0]  bn;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic [31:0] qa;
    logic [31:0] qb;
    logic        ba;
    logic        bb;
    logic [31:0] qa_nb;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [4:0] wn, input logic [31:0] d, input logic [3:0] wbe,
                              input logic sb, input logic [4:0] bn, input logic [4:0] rna, input logic [4:0] rnb,
                              input logic [31:0] qa, input logic [31:0] qb, input logic ba, input logic bb,
                              input logic [31:0] qa_nb);
    vec_t v;
    v.we = we; v.wn = wn; v.d = d; v.wbe = wbe; v.sb = sb; v.bn = bn; v.rna = rna; v.rnb = rnb;
    v.qa = qa; v.qb = qb; v.ba = ba; v.bb = bb; v.qa_nb = qa_nb;
    return v;
  endfunction

  vec_t vt [19];

  initial begin
    n_cmp = 0;
    n_err = 0;
    //           we wn  d             wbe  sb bn rna rnb  qa            qb            ba bb qa_nb
    vt[0]  = mk(1, 0,  32'hFFFFFFFF, 4'hF, 0, 0, 0,  0,  32'h0,        32'h0,        0, 0, 32'h0);
    vt[1]  = mk(1, 12, 32'd12,       4'hF, 0, 0, 0,  12, 32'h0,        32'd12,       0, 0, 32'h0);
    vt[2]  = mk(1, 5,  32'd5,        4'hF, 0, 0, 12, 0,  32'd12,       32'h0,        0, 0, 32'd12);
    vt[3]  = mk(1, 10, 32'd10,       4'hF, 0, 0, 5,  10, 32'd5,        32'd10,       0, 0, 32'd5);
    vt[4]  = mk(0, 0,  32'h0,        4'h0, 0, 0, 10, 5,  32'd10,       32'd5,        0, 0, 32'd10);
    vt[5]  = mk(1, 10, 32'd30,       4'hF, 0, 0, 10, 12, 32'd30,       32'd12,       0, 0, 32'd10);
    vt[6]  = mk(0, 0,  32'h0,        4'h0, 0, 0, 10, 5,  32'd30,       32'd5,        0, 0, 32'd30);
    vt[7]  = mk(1, 7,  32'h12345678, 4'hF, 0, 0, 7,  7,  32'h12345678, 32'h12345678, 0, 0, 32'h0);
    vt[8]  = mk(1, 3,  32'hAABBCCDD, 4'hF, 0, 0, 7,  3,  32'h12345678, 32'hAABBCCDD, 0, 0, 32'h12345678);
    vt[9]  = mk(1, 3,  32'h11223344, 4'h5, 0, 0, 3,  3,  32'hAA22CC44, 32'hAA22CC44, 0, 0, 32'hAABBCCDD);
    vt[10] = mk(0, 0,  32'h0,        4'h0, 1, 9, 3,  9,  32'hAA22CC44, 32'h0,        0, 0, 32'hAA22CC44);
    vt[11] = mk(0, 0,  32'h0,        4'h0, 0, 0, 9,  9,  32'h0,        32'h0,        1, 1, 32'h0);
    vt[12] = mk(1, 9,  32'd99,       4'hF, 0, 0, 9,  3,  32'd99,       32'hAA22CC44, 0, 0, 32'h0);
    vt[13] = mk(1, 9,  32'h55,       4'hF, 1, 9, 3,  3,  32'hAA22CC44, 32'hAA22CC44, 0, 0, 32'hAA22CC44);
    vt[14] = mk(0, 0,  32'h0,        4'h0, 0, 0, 9,  0,  32'h55,       32'h0,        1, 0, 32'h55);
    vt[15] = mk(0, 0,  32'h0,        4'h0, 1, 0, 9,  0,  32'h55,       32'h0,        1, 0, 32'h55);
    vt[16] = mk(0, 0,  32'h0,        4'h0, 0, 0, 0,  9,  32'h0,        32'h55,       0, 1, 32'h0);
    vt[17] = mk(1, 9,  32'hFFFFFFFF, 4'h0, 0, 0, 9,  9,  32'h55,       32'h55,       0, 0, 32'h55);
    vt[18] = mk(0, 0,  32'h0,        4'h0, 0, 0, 9,  12, 32'h55,       32'd12,       0, 0, 32'h55);

    // Reset held for two cycles, then every register reads zero and idle.
    clrn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
      #1;
      chk("rst_qa", i, bus.qa, 32'h0);
      chk("rst_busy_a", i, {31'h0, bus.busy_a}, 32'h0);
      @(posedge clk);
      model_step();
    end

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vt[i].we, vt[i].wn, vt[i].d, vt[i].wbe, vt[i].sb, vt[i].bn, vt[i].rna, vt[i].rnb);
      #1;
      chk("vec_qa", i, bus.qa, vt[i].qa);
      chk("vec_qb", i, bus.qb, vt[i].qb);
      chk("vec_busy_a", i, {31'h0, bus.busy_a}, {31'h0, vt[i].ba});
      chk("vec_busy_b", i, {31'h0, bus.busy_b}, {31'h0, vt[i].bb});
      chk("vec_qa_nobyp", i, bus_nb.qa, vt[i].qa_nb);
      @(posedge clk);
      model_step();
    end

    for (int i = 0; i < 400; i++) begin
      logic [4:0] ra, rb;
      @(negedge clk);
      ra = (i % 5 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rb = (i % 7 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, 4'($urandom),
            ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), ra, rb);
      #1;
      chk("rnd_qa", i, bus.qa, exp_q(ra, 1));
      chk("rnd_qb", i, bus.qb, exp_q(rb, 1));
      chk("rnd_qa_nobyp", i, bus_nb.qa, exp_q(ra, 0));
      chk("rnd_qb_nobyp", i, bus_nb.qb, exp_q(rb, 0));
      if (!(bus.set_busy && bus.bn == ra && bus.we && bus.wn == ra))
        chk("rnd_busy_a", i, {31'h0, bus.busy_a}, {31'h0, exp_b(ra)});
      if (!(bus.set_busy && bus.bn == rb && bus.we && bus.wn == rb))
        chk("rnd_busy_b", i, {31'h0, bus.busy_b}, {31'h0, exp_b(rb)});
      @(posedge clk);
      model_step();
    end

    // Asynchronous reset pulse between edges while state is populated.
    step(1, 1, 32'h11111111, 4'hF, 0, 0, 0, 0);
    step(1, 2, 32'h22222222, 4'hF, 0, 0, 0, 0);
    step(1, 3, 32'h33333333, 4'hF, 0, 0, 0, 0);
    step(1, 4, 32'h44444444, 4'hF, 1, 2, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 2, 4);
    #1;
    chk("pre_rst_qa", 0, bus.qa, 32'h22222222);
    chk("pre_rst_qb", 0, bus.qb, 32'h44444444);
    chk("pre_rst_busy_a", 0, {31'h0, bus.busy_a}, 32'h1);
    clrn = 1'b0;
    #1;
    chk("in_rst_qa", 0, bus.qa, 32'h0);
    chk("in_rst_qb", 0, bus.qb, 32'h0);
    chk("in_rst_busy_a", 0, {31'h0, bus.busy_a}, 32'h0);
    #2;
    clrn = 1'b1;
    model_reset();
    @(posedge clk);
    model_step();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 5'(i), 5'(i));
      #1;
      chk("post_rst_qa", i, bus.qa, 32'h0);
      chk("post_rst_busy_a", i, {31'h0, bus.busy_a}, 32'h0);
      @(posedge clk);
      model_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
